// File: rtl/regression_sample_feeder_pkg.sv
// Shared definitions for the regression sample feeder and the coefficient calculator.
// Holds the default dataset geometry and the feeder state encoding.
package regression_sample_feeder_pkg;

  localparam int N_DEFAULT      = 150;
  localparam int DATA_W_DEFAULT = 20;
  localparam int ADDR_W_DEFAULT = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FILL     = 3'd1,
    MEAN_REQ = 3'd2,
    MEAN_RUN = 3'd3,
    CALC_REQ = 3'd4,
    CALC_RUN = 3'd5,
    DONE     = 3'd6
  } state_t;

  // The replay states are the only ones in which ldX is legal.
  function automatic logic is_run(input state_t s);
    return (s == MEAN_RUN) || (s == CALC_RUN);
  endfunction

endpackage

// File: rtl/regression_sample_feeder_if.sv
// Sample stream and calculator handshake bundle between the feeder and its neighbours.
// The master side drives the stimulus/acks; the slave side is the feeder.
interface regression_sample_feeder_if
  import regression_sample_feeder_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
);
  logic              start;
  logic              inValid;
  logic [DATA_W-1:0] inX;
  logic [DATA_W-1:0] inY;
  logic              inReady;
  logic              meanStart;
  logic              calcStart;
  logic              meanReady;
  logic              calcReady;
  logic              ldX;
  logic [DATA_W-1:0] x;
  logic [DATA_W-1:0] y;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, inValid, inX, inY, meanReady, calcReady, ldX,
    input  inReady, meanStart, calcStart, x, y, busy, done, err
  );

  modport slave (
    input  start, inValid, inX, inY, meanReady, calcReady, ldX,
    output inReady, meanStart, calcStart, x, y, busy, done, err
  );
endinterface

// File: rtl/regression_sample_feeder_ram.sv
// Sample store: one synchronous write port, one combinational read port.
// Each word holds a packed {x, y} pair.
module regression_sample_ram #(
  parameter int DEPTH  = 150,
  parameter int WIDTH  = 40,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wAddr,
  input  logic [WIDTH-1:0]  wData,
  input  logic [ADDR_W-1:0] rAddr,
  output logic [WIDTH-1:0]  rData
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wAddr] <= wData;
    end
  end

  assign rData = mem[rAddr];
endmodule

// File: rtl/regression_sample_feeder.sv
// Collects N (x,y) pairs, then replays them twice (mean pass, coefficient pass)
// into the regression calculator under its start/ready/ldX handshake.
module regression_sample_feeder
  import regression_sample_feeder_pkg::*;
#(
  parameter int N      = N_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  regression_sample_feeder_if.slave  bus
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
  logic              err_q, err_d;
  logic              ram_we;
  logic [2*DATA_W-1:0] ram_rdata;

  regression_sample_ram #(
    .DEPTH  (N),
    .WIDTH  (2 * DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .wAddr (wr_addr_q),
    .wData ({bus.inX, bus.inY}),
    .rAddr (rd_addr_q),
    .rData (ram_rdata)
  );

  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    rd_cnt_d  = rd_cnt_q;
    err_d     = err_q;
    ram_we    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = FILL;
          wr_addr_d = '0;
          err_d     = 1'b0;
        end
      end
      FILL: begin
        if (bus.inValid) begin
          ram_we    = 1'b1;
          wr_addr_d = wr_addr_q + ADDR_W'(1);
          if (wr_addr_q == LAST) state_d = MEAN_REQ;
        end
      end
      MEAN_REQ, CALC_REQ: begin
        if ((state_q == MEAN_REQ) ? bus.meanReady : bus.calcReady) begin
          rd_addr_d = '0;
          rd_cnt_d  = '0;
          state_d   = (state_q == MEAN_REQ) ? MEAN_RUN : CALC_RUN;
        end
      end
      MEAN_RUN, CALC_RUN: begin
        if (bus.ldX) begin
          rd_cnt_d = rd_cnt_q + ADDR_W'(1);
          // Hold the read address on the final pair so it never points past N-1.
          if (rd_cnt_q == LAST) begin
            state_d = (state_q == MEAN_RUN) ? CALC_REQ : DONE;
          end else begin
            rd_addr_d = rd_addr_q + ADDR_W'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (bus.ldX && !is_run(state_q)) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      rd_cnt_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      rd_cnt_q  <= rd_cnt_d;
      err_q     <= err_d;
    end
  end

  assign bus.inReady   = (state_q == FILL);
  assign bus.meanStart = (state_q == MEAN_REQ);
  assign bus.calcStart = (state_q == CALC_REQ);
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.err       = err_q;
  assign bus.x         = ram_rdata[2*DATA_W-1:DATA_W];
  assign bus.y         = ram_rdata[DATA_W-1:0];
endmodule

// File: tb/tb_regression_sample_feeder.sv
// Bench for regression_sample_feeder: table of single-cycle boundary vectors, directed
// dataset sequences, and randomized datasets checked against an expected-replay model.
module tb_regression_sample_feeder;
  import regression_sample_feeder_pkg::*;

  localparam int N  = N_DEFAULT;
  localparam int DW = DATA_W_DEFAULT;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regression_sample_feeder_if #(.DATA_W(DW)) bus();

  regression_sample_feeder #(
    .N      (N),
    .DATA_W (DW),
    .ADDR_W (ADDR_W_DEFAULT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Model: the dataset that was streamed in is exactly what each pass must replay.
  logic [DW-1:0] exp_x [N];
  logic [DW-1:0] exp_y [N];

  typedef struct packed {
    logic start, in_valid, ld_x, mean_ready, calc_ready;
    logic exp_busy, exp_in_ready, exp_err;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.start = 1'b0; bus.inValid = 1'b0; bus.inX = '0; bus.inY = '0;
    bus.meanReady = 1'b0; bus.calcReady = 1'b0; bus.ldX = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},      64'(bus.busy),      64'd0);
    chk({tag, "_inReady"},   64'(bus.inReady),   64'd0);
    chk({tag, "_meanStart"}, 64'(bus.meanStart), 64'd0);
    chk({tag, "_calcStart"}, 64'(bus.calcStart), 64'd0);
    chk({tag, "_done"},      64'(bus.done),      64'd0);
    chk({tag, "_err"},       64'(bus.err),       64'd0);
  endtask

  task automatic do_reset(input string tag);
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk_reset_outputs(tag);
    $display("reset %s: outputs checked", tag);
  endtask

  task automatic fill(input int gap_at, input int gap_len, input bit rand_gaps);
    int accepts;
    int g;
    accepts = 0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("fill_err_cleared", 64'(bus.err), 64'd0);
    for (int i = 0; i < N; i++) begin
      g = 0;
      if (i == gap_at) g = gap_len;
      else if (rand_gaps && $urandom_range(0, 7) == 0) g = int'($urandom_range(1, 3));
      bus.inValid = 1'b0;
      for (int k = 0; k < g; k++) begin
        chk("fill_gap_inReady", 64'(bus.inReady), 64'd1);
        chk("fill_gap_meanStart", 64'(bus.meanStart), 64'd0);
        tick();
      end
      bus.inValid = 1'b1;
      bus.inX = exp_x[i];
      bus.inY = exp_y[i];
      if (bus.inReady) accepts++;
      chk("fill_meanStart_early", 64'(bus.meanStart), 64'd0);
      tick();
    end
    bus.inValid = 1'b0;
    chk("fill_accepts", 64'(accepts), 64'(N));
    chk("meanStart_latency", 64'(bus.meanStart), 64'd1);
    chk("fill_inReady_after", 64'(bus.inReady), 64'd0);
    $display("fill: %0d samples accepted, x[0]=%0h x[N-1]=%0h", accepts, exp_x[0], exp_x[N-1]);
  endtask

  // One replay pass: request/ack handshake followed by N ldX strobes.
  task automatic run_pass(input bit calc, input int spacing, input bit rand_sp, input int hold,
                          input bit coincide, input int abort_at, input bit exp_err);
    int gap;
    for (int k = 0; k <= hold; k++) begin
      if (calc) chk("calcStart_held", 64'(bus.calcStart), 64'd1);
      else      chk("meanStart_held", 64'(bus.meanStart), 64'd1);
      if (k < hold) tick();
    end
    if (calc) bus.calcReady = 1'b1;
    else      bus.meanReady = 1'b1;
    bus.ldX = coincide;
    tick();
    bus.meanReady = 1'b0;
    bus.calcReady = 1'b0;
    bus.ldX       = 1'b0;
    if (calc) chk("calcStart_drop", 64'(bus.calcStart), 64'd0);
    else      chk("meanStart_drop", 64'(bus.meanStart), 64'd0);
    for (int k = 0; k < N; k++) begin
      if (k == abort_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_outputs("abort");
        $display("pass calc=%0d: reset at sample %0d", calc, k);
        return;
      end
      gap = rand_sp ? int'($urandom_range(0, 3)) : spacing - 1;
      for (int j = 0; j < gap; j++) begin
        if (calc && rand_sp) bus.calcReady = 1'($urandom_range(0, 1));
        tick();
      end
      bus.calcReady = 1'b0;
      bus.ldX = 1'b1;
      chk("replay_x", 64'(bus.x), 64'(exp_x[k]));
      chk("replay_y", 64'(bus.y), 64'(exp_y[k]));
      chk("done_early", 64'(bus.done), 64'd0);
      tick();
      bus.ldX = 1'b0;
    end
    if (!calc) begin
      chk("calcStart_after_mean", 64'(bus.calcStart), 64'd1);
      chk("meanStart_after_mean", 64'(bus.meanStart), 64'd0);
    end else begin
      chk("done_pulse", 64'(bus.done), 64'd1);
      chk("busy_in_done", 64'(bus.busy), 64'd1);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      chk("done_single", 64'(bus.done), 64'd0);
      chk("busy_idle_start_in_done", 64'(bus.busy), 64'd0);
    end
    chk("pass_err", 64'(bus.err), 64'(exp_err));
    $display("pass calc=%0d: %0d pairs replayed, err=%0d", calc, N, bus.err);
  endtask

  task automatic load_linear(input int base);
    for (int i = 0; i < N; i++) begin
      exp_x[i] = DW'(base + i);
      exp_y[i] = DW'(2 * i + 1);
    end
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;

    // start, inValid, ldX, meanReady, calcReady | busy, inReady, err
    tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    do_reset("init");

    for (int i = 0; i < 8; i++) begin
      bus.start     = tbl[i].start;
      bus.inValid   = tbl[i].in_valid;
      bus.ldX       = tbl[i].ld_x;
      bus.meanReady = tbl[i].mean_ready;
      bus.calcReady = tbl[i].calc_ready;
      bus.inX       = DW'(i);
      bus.inY       = DW'(i);
      tick();
      clear_inputs();
      chk("tbl_busy",    64'(bus.busy),    64'(tbl[i].exp_busy));
      chk("tbl_inReady", 64'(bus.inReady), 64'(tbl[i].exp_in_ready));
      chk("tbl_err",     64'(bus.err),     64'(tbl[i].exp_err));
      chk("tbl_meanStart", 64'(bus.meanStart), 64'd0);
      $display("table row %0d applied", i);
    end
    do_reset("mid_fill");

    // Dataset A: back-to-back fill, spacing 2 then 4.
    load_linear(0);
    fill(-1, 0, 1'b0);
    run_pass(1'b0, 2, 1'b0, 2, 1'b0, -1, 1'b0);
    run_pass(1'b1, 4, 1'b0, 1, 1'b0, -1, 1'b0);

    // ldX in IDLE sets err; the next accepted start clears it.
    bus.ldX = 1'b1;
    tick();
    bus.ldX = 1'b0;
    chk("idle_ldX_err", 64'(bus.err), 64'd1);
    chk("idle_ldX_busy", 64'(bus.busy), 64'd0);

    // Dataset B: 3-cycle stall after sample 10; ack coincident with ldX.
    load_linear(0);
    fill(11, 3, 1'b0);
    run_pass(1'b0, 1, 1'b0, 0, 1'b1, -1, 1'b1);
    run_pass(1'b1, 1, 1'b0, 0, 1'b0, -1, 1'b1);

    // Dataset C: reset in the middle of the coefficient pass, then a fresh dataset.
    load_linear(0);
    fill(-1, 0, 1'b0);
    run_pass(1'b0, 1, 1'b0, 0, 1'b0, -1, 1'b0);
    run_pass(1'b1, 1, 1'b0, 0, 1'b0, 75, 1'b0);
    load_linear(1000);
    fill(-1, 0, 1'b0);
    run_pass(1'b0, 2, 1'b0, 0, 1'b0, -1, 1'b0);
    run_pass(1'b1, 3, 1'b0, 0, 1'b0, -1, 1'b0);

    // Randomized datasets with random gaps, holds, spacings and stray calcReady.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N; i++) begin
        exp_x[i] = DW'($urandom);
        exp_y[i] = DW'($urandom);
      end
      fill(-1, 0, 1'b1);
      run_pass(1'b0, 1, 1'b1, int'($urandom_range(0, 4)), 1'b0, -1, 1'b0);
      run_pass(1'b1, 1, 1'b1, int'($urandom_range(0, 4)), 1'b0, -1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/regression_sample_feeder.md
Name: regression_sample_feeder

Overview:
- Upstream data stage for the linear-regression coefficient calculator.
- Accepts N (x,y) sample pairs over a valid/ready input stream and stores them in an internal sample RAM.
- Replays all N pairs twice into the calculator: once for the mean pass, once for the coefficient pass.
- Drives the calculator's meanStart/calcStart and follows its meanReady/calcReady and ldX strobes.

Parameters:
N, 150, samples per dataset (must match the calculator's loop count)
DATA_W, 20, width of each x and y sample (signed fixed point, passed through untouched)
ADDR_W, 8, address/counter width; must satisfy 2^ADDR_W >= N+1

Ports:
clk  in  1  clock, all state changes on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  begin a new dataset (fill then replay); sampled in IDLE only
inValid  in  1  input sample valid
inX  in  DATA_W  input x sample
inY  in  DATA_W  input y sample
inReady  out  1  feeder accepts a sample this cycle
meanStart  out  1  request to calculator to begin mean pass
calcStart  out  1  request to calculator to begin coefficient pass
meanReady  in  1  calculator acknowledged mean pass (one-cycle pulse)
calcReady  in  1  calculator acknowledged coefficient pass / per-sample B update
ldX  in  1  calculator consumes current pair this cycle (ldY is identical and not needed)
x  out  DATA_W  current sample x = mem[rdAddr]
y  out  DATA_W  current sample y = mem[rdAddr]
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when the coefficient pass has consumed N pairs
err  out  1  sticky: ldX seen outside a RUN state or beyond N; cleared by rst or an accepted start

Behaviour:
- Reset values:
  - state=IDLE; wrAddr=0, rdAddr=0, rdCnt=0.
  - inReady, meanStart, calcStart, busy, done, err all 0.
  - RAM contents are not cleared.
  - x/y are don't-care until the first FILL completes.
- States and transitions:
  - IDLE:
    - start=1 -> FILL; clears wrAddr and err.
  - FILL:
    - inReady=1.
    - On inValid&inReady: mem[wrAddr]<={inX,inY}, wrAddr++.
    - The accept of sample N-1 -> MEAN_REQ on the next edge.
    - No backpressure gaps are required; 1 sample/cycle sustained.
  - MEAN_REQ:
    - meanStart=1, held until meanReady=1 is sampled.
    - On meanReady: rdAddr=0, rdCnt=0 -> MEAN_RUN.
  - MEAN_RUN:
    - x/y = combinational read of mem[rdAddr]; valid from the first MEAN_RUN cycle.
    - Each ldX: rdAddr++, rdCnt++.
    - When rdCnt reaches N, meaning the Nth ldX was accepted -> CALC_REQ.
  - CALC_REQ:
    - calcStart=1, held until calcReady=1 is sampled.
    - On calcReady: rdAddr=0, rdCnt=0 -> CALC_RUN.
  - CALC_RUN:
    - Same read/advance rule as MEAN_RUN.
    - calcReady pulses during CALC_RUN are ignored.
    - On the Nth ldX -> DONE.
  - DONE:
    - done=1 for exactly one cycle -> IDLE.
- Latency:
  - From the last FILL accept to meanStart: 1 cycle.
  - The pair consumed by ldX in cycle t is mem[rdAddr(t)]; the next pair is visible in cycle t+1.
- Boundaries:
  - start outside IDLE is ignored.
  - inValid outside FILL is ignored; inReady=0 there.
  - ldX in IDLE/FILL/REQ/DONE states is ignored, no address change, and sets err.
  - meanReady and ldX in the same cycle: the acknowledge wins; the address is reset and ldX is ignored.
  - rdAddr never exceeds N-1 as a read address; after the Nth ldX the state leaves RUN.
  - rst mid-FILL or mid-RUN: returns to IDLE at the next edge with all outputs at reset values. Partially written RAM is retained but is invalid until a new FILL.
  - start in the same cycle as DONE is ignored; start is accepted from the following IDLE cycle.
- Arithmetic: counters are unsigned ADDR_W bits with no wrap inside a pass; samples are stored and output bit-exact.

Decomposition:
- Shared package:
  - state encoding constants IDLE, FILL, MEAN_REQ, MEAN_RUN, CALC_REQ, CALC_RUN, DONE (3-bit);
  - default N and DATA_W, shared with the calculator.
- Sub-module regression_sample_ram:
  - N x 2*DATA_W;
  - synchronous write port (we, wAddr, wData);
  - asynchronous read port (rAddr -> rData).
- The FSM and counters stay in the top.

Test Plan:
- Reset then start=1, stream N=150 pairs x=i, y=2i+1 back-to-back -> inReady high for exactly 150 accepts; meanStart rises 1 cycle after the last accept.
- Pulse meanReady, then issue 150 ldX spaced 2 cycles apart (MeanLdXY/MeanLdSum cadence) -> x/y sequence 0..149 / 1..299 in order; calcStart asserted after the 150th ldX; err=0.
- Pulse calcReady, issue 150 ldX spaced 4 cycles apart -> same data replayed from index 0; done pulses exactly once, 1 cycle after the 150th ldX; busy falls with the return to IDLE.
- Hold inValid low for 3 cycles after sample 10 during FILL -> wrAddr stalls at 11; the replayed stream is still 0..149 with no duplicates.
- ldX pulse in IDLE, and meanReady coincident with ldX -> err=1 sticky, no address change; the first replayed x after the ack is 0.
- rst asserted at sample 75 of CALC_RUN -> next cycle IDLE with all outputs 0; a new start plus fill of x=1000+i replays correctly from 1000.
